// File: rtl/mul_seq_ctrl.sv
// Control FSM for a repeated-addition multiplier datapath.
// Collects operand A then operand B over a valid/ready handshake, clears P,
// then adds A into P once per cycle while decrementing B until B reaches zero
// or the iteration limit is hit. The result is held with done until res_ack.
// Strobes are decoded combinationally from the state register and inputs, and
// every output is forced low while rst is high.

module mul_seq_ctrl #(
    parameter int unsigned MAX_ITER = 65535,
    parameter int unsigned CW       = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          eqz,
    output logic          LdA,
    output logic          LdB,
    output logic          LdP,
    output logic          clrP,
    output logic          decB,
    output logic          busy,
    output logic          done,
    input  logic          res_ack,
    output logic          err,
    output logic [CW-1:0] iter_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_RUN    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [CW-1:0] MAX_ITER_C = CW'(MAX_ITER);
    localparam logic [CW-1:0] ONE_C      = CW'(1);

    state_t        state_r;
    logic [CW-1:0] iter_cnt_r;
    logic          err_r;
    logic          at_limit_s;

    logic          in_ready_s;
    logic          lda_s;
    logic          ldb_s;
    logic          ldp_s;
    logic          clrp_s;
    logic          decb_s;

    assign at_limit_s = (iter_cnt_r == MAX_ITER_C);

    // Strobe and handshake decode; reset and abort silence everything.
    always_comb begin
        in_ready_s = 1'b0;
        lda_s      = 1'b0;
        ldb_s      = 1'b0;
        ldp_s      = 1'b0;
        clrp_s     = 1'b0;
        decb_s     = 1'b0;
        if (rst || abort) begin
            in_ready_s = 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    in_ready_s = 1'b0;
                end
                S_LOAD_A: begin
                    in_ready_s = 1'b1;
                    clrp_s     = 1'b1;
                    lda_s      = in_valid;
                end
                S_LOAD_B: begin
                    in_ready_s = 1'b1;
                    ldb_s      = in_valid;
                end
                S_RUN: begin
                    if (!eqz && !at_limit_s) begin
                        ldp_s  = 1'b1;
                        decb_s = 1'b1;
                    end else begin
                        ldp_s  = 1'b0;
                        decb_s = 1'b0;
                    end
                end
                S_DONE: begin
                    in_ready_s = 1'b0;
                end
                default: begin
                    in_ready_s = 1'b0;
                end
            endcase
        end
    end

    // Sequencer: state, iteration counter and limit flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_IDLE;
            iter_cnt_r <= {CW{1'b0}};
            err_r      <= 1'b0;
        end else if (abort) begin
            state_r    <= S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        state_r    <= S_LOAD_A;
                        iter_cnt_r <= {CW{1'b0}};
                        err_r      <= 1'b0;
                    end
                end
                S_LOAD_A: begin
                    if (in_valid) begin
                        state_r <= S_LOAD_B;
                    end
                end
                S_LOAD_B: begin
                    if (in_valid) begin
                        state_r <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (eqz) begin
                        state_r <= S_DONE;
                    end else if (at_limit_s) begin
                        err_r   <= 1'b1;
                        state_r <= S_DONE;
                    end else begin
                        iter_cnt_r <= iter_cnt_r + ONE_C;
                    end
                end
                S_DONE: begin
                    if (res_ack) begin
                        state_r <= S_IDLE;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready = in_ready_s;
    assign LdA      = lda_s;
    assign LdB      = ldb_s;
    assign LdP      = ldp_s;
    assign clrP     = clrp_s;
    assign decB     = decb_s;
    assign busy     = ~rst & (state_r != S_IDLE);
    assign done     = ~rst & (state_r == S_DONE);
    assign err      = ~rst & err_r;
    assign iter_cnt = rst ? {CW{1'b0}} : iter_cnt_r;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Bench for mul_seq_ctrl: a behavioural datapath (A, B, P registers) closes
// the loop around the controller; expected results are queued when each
// operation is started and a monitor pops and compares them on done.

module tb_mul_seq_ctrl;

    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst, start, abort, in_valid, eqz, res_ack;
    logic          in_ready, LdA, LdB, LdP, clrP, decB, busy, done, err;
    logic [CW-1:0] iter_cnt;

    int passed = 0;
    int total  = 0;
    int viol   = 0;

    always #5 clk = ~clk;

    mul_seq_ctrl #(.MAX_ITER(4), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .eqz(eqz),
        .LdA(LdA), .LdB(LdB), .LdP(LdP), .clrP(clrP), .decB(decB),
        .busy(busy), .done(done), .res_ack(res_ack), .err(err),
        .iter_cnt(iter_cnt)
    );

    // Behavioural datapath driven by the strobes
    logic [15:0] a_r = 16'd0, b_r = 16'd0, p_r = 16'd0;
    logic [15:0] op_a = 16'd0, op_b = 16'd0;
    logic [15:0] data_in;
    int          nb = 0;
    int          ldp_cnt = 0;

    assign data_in = (nb == 0) ? op_a : op_b;
    assign eqz     = (b_r == 16'd0);

    always @(posedge clk) begin
        if (LdA) a_r <= data_in;
        if (LdB) b_r <= data_in;
        else if (decB) b_r <= b_r - 16'd1;
        if (clrP) p_r <= 16'd0;
        else if (LdP) p_r <= p_r + a_r;
    end

    always @(posedge clk) begin
        if (start && !busy) begin
            nb      <= 0;
            ldp_cnt <= 0;
        end else begin
            if (in_ready && in_valid) nb <= nb + 1;
            if (LdP) ldp_cnt <= ldp_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act === exp_v) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    endtask

    function automatic logic [7:0] vec();
        return {LdA, LdB, LdP, decB, clrP, in_ready, busy, done};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard
    typedef struct {
        logic [15:0]   p;
        logic [CW-1:0] it;
        logic          e;
    } exp_t;
    exp_t exp_q[$];
    logic done_q = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (done && !done_q) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_done: got done=1 expected no result at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                check("result_p", 32'(p_r), 32'(e.p));
                check("result_iter", 32'(iter_cnt), 32'(e.it));
                check("result_err", 32'(err), 32'(e.e));
            end
        end
        done_q <= done;
        if ((int'(LdA) + int'(LdB) + int'(LdP)) > 1 || (clrP && LdP) || (LdP != decB))
            viol <= viol + 1;
    end

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int sa, input int sb,
                          input logic [15:0] ep, input logic [CW-1:0] eit, input logic ee,
                          input bit noisy);
        exp_t e;
        int   n;
        op_a = a; op_b = b;
        e.p = ep; e.it = eit; e.e = ee;
        exp_q.push_back(e);
        start = 1'b1; in_valid = 1'b0;
        step();
        start = 1'b0;
        check("start_clears", {15'd0, err, iter_cnt}, 32'd0);
        repeat (sa) begin
            @(negedge clk); check("stall_a", {in_ready, LdA}, 2'b10); step();
        end
        in_valid = 1'b1;
        @(negedge clk); check("accept_a", {in_ready, LdA, clrP}, 3'b111); step();
        in_valid = 1'b0;
        repeat (sb) begin
            @(negedge clk); check("stall_b", {in_ready, LdB}, 2'b10); step();
        end
        in_valid = 1'b1;
        @(negedge clk); check("accept_b", {in_ready, LdB}, 2'b11); step();
        in_valid = 1'b0;
        n = 0;
        while (!done && n < 300) begin
            if (noisy) begin
                start   = n[0];
                res_ack = ~n[0];
            end
            step();
            n++;
        end
        start = 1'b0; res_ack = 1'b0;
        check("run_cycles", 32'(n), 32'(eit) + 32'd1);
        check("ldp_pulses", 32'(ldp_cnt), 32'(eit));
        repeat (2) begin
            start = noisy;
            @(negedge clk); check("done_held", vec(), 8'b0000_0011);
            step();
        end
        start = 1'b0;
        res_ack = 1'b1;
        step();
        res_ack = 1'b0;
        @(negedge clk); check("idle_after_ack", vec(), 8'd0);
        step();
    endtask

    logic [7:0] nom_tbl [0:10];

    initial begin
        nom_tbl[0]  = 8'b0000_0000; nom_tbl[1]  = 8'b1000_1110; nom_tbl[2]  = 8'b0100_0110;
        nom_tbl[3]  = 8'b0011_0010; nom_tbl[4]  = 8'b0011_0010; nom_tbl[5]  = 8'b0011_0010;
        nom_tbl[6]  = 8'b0000_0010; nom_tbl[7]  = 8'b0000_0011; nom_tbl[8]  = 8'b0000_0011;
        nom_tbl[9]  = 8'b0000_0011; nom_tbl[10] = 8'b0000_0000;

        rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; res_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); check("reset_outputs", {vec(), iter_cnt, err}, 32'd0);
        step();
        rst = 1'b0;
        @(negedge clk); check("post_reset_idle", {vec(), iter_cnt, err}, 32'd0);
        step();

        // Nominal: A=5, B=3, cycle-accurate strobe trace
        op_a = 16'd5; op_b = 16'd3;
        exp_q.push_back('{p: 16'd15, it: 16'd3, e: 1'b0});
        in_valid = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            start   = (c == 0);
            res_ack = (c == 9);
            @(negedge clk); check($sformatf("nominal_c%0d", c), vec(), nom_tbl[c]);
            step();
        end
        start = 1'b0; res_ack = 1'b0; in_valid = 1'b0;

        // Reset in the 4th RUN cycle of A=7, B=9
        op_a = 16'd7; op_b = 16'd9;
        start = 1'b1; step(); start = 1'b0;
        in_valid = 1'b1; step(); step(); in_valid = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        @(negedge clk); check("rst_midrun_outputs", {vec(), iter_cnt, err}, 32'd0);
        step();
        rst = 1'b0;
        @(negedge clk); check("rst_midrun_idle", {vec(), iter_cnt, err}, 32'd0);
        step();
        run_op(16'd7, 16'd4, 0, 0, 16'd28, 16'd4, 1'b0, 1'b0);

        // Iteration limit, then stalls with B=0 (err cleared by the new start)
        run_op(16'd3, 16'd10, 0, 0, 16'd12, 16'd4, 1'b1, 1'b0);
        run_op(16'd9, 16'd0, 3, 2, 16'd0, 16'd0, 1'b0, 1'b0);
        run_op(16'd0, 16'd3, 0, 0, 16'd0, 16'd3, 1'b0, 1'b0);

        // Abort in the 5th RUN cycle of A=2, B=100
        op_a = 16'd2; op_b = 16'd100;
        start = 1'b1; step(); start = 1'b0;
        in_valid = 1'b1; step(); step(); in_valid = 1'b0;
        repeat (4) step();
        abort = 1'b1;
        @(negedge clk); check("abort_strobes", vec(), 8'b0000_0010);
        step();
        abort = 1'b0;
        check("abort_idle", {busy, done, iter_cnt, err}, {13'd0, 1'b0, 1'b0, 16'd4, 1'b0});
        run_op(16'd6, 16'd2, 0, 0, 16'd12, 16'd2, 1'b0, 1'b0);

        // start with abort in IDLE stays idle
        start = 1'b1; abort = 1'b1; step();
        start = 1'b0; abort = 1'b0;
        check("start_abort_idle", 32'(busy), 32'd0);
        step();

        // Stray start/res_ack pulses during RUN and DONE
        run_op(16'd4, 16'd3, 0, 0, 16'd12, 16'd3, 1'b0, 1'b1);

        check("strobe_exclusive", 32'(viol), 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Control FSM for the repeated-addition multiplier datapath (A register, P accumulator, B down-counter, adder, zero comparator).
- Accepts two operands over the shared 16-bit data_in bus with a valid/ready handshake: first A, then B.
- Drives the load, clear and decrement strobes, then iterates P <= P + A until B reaches zero.
- Presents the result with a done/ack handshake; supports abort and an iteration-limit error.

Parameters:
- MAX_ITER, 65535: maximum add iterations before forced termination with err=1; legal range 1..65535.
- CW, 16: width of the iter_cnt output and internal counter.

Ports:
- clk  input  1  system clock, all state on posedge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a new multiply; sampled only in IDLE
- abort  input  1  synchronous abort; returns to IDLE from any state
- in_valid  input  1  operand present on data_in (operand source side)
- in_ready  output  1  controller is accepting an operand this cycle
- eqz  input  1  datapath comparator: B counter == 0
- LdA  output  1  load A from bus
- LdB  output  1  load B counter from bus
- LdP  output  1  load P with adder output
- clrP  output  1  clear P
- decB  output  1  decrement B counter
- busy  output  1  high in every state except IDLE
- done  output  1  result valid in P; held until res_ack
- res_ack  input  1  consumer accepts result
- err  output  1  iteration limit hit on the current or last operation
- iter_cnt  output  CW  add iterations performed on the current or last operation

Behaviour:
- States: IDLE, LOAD_A, LOAD_B, RUN, DONE. Registered state.
- Strobes and in_ready are combinational from state and inputs.
- When rst=1, all outputs are forced to 0, regardless of state.
- On reset: state=IDLE, iter_cnt=0, err=0, and all strobes, busy and done are 0.
- abort has top priority over every other input.
  - In any state, abort=1 sends the next state to IDLE and drives all strobes to 0 that cycle.
  - iter_cnt and err hold their values.
- IDLE:
  - Outputs: busy=0, in_ready=0, no strobes.
  - start=1 → LOAD_A; on that edge iter_cnt and err clear to 0.
- LOAD_A:
  - Outputs: in_ready=1, clrP=1, LdA=in_valid.
  - in_valid=1 → LOAD_B; otherwise stay.
- LOAD_B:
  - Outputs: in_ready=1, LdB=in_valid.
  - in_valid=1 → RUN; otherwise stay.
- RUN: eqz is evaluated every cycle against the current B.
  - eqz=1: no strobes, → DONE.
  - eqz=0 and iter_cnt==MAX_ITER: no strobes, err<=1, → DONE.
  - Otherwise: LdP=1 and decB=1 in the same cycle, iter_cnt<=iter_cnt+1, stay.
- DONE:
  - Outputs: done=1, no strobes.
  - P holds the product; A and B must not be disturbed.
  - res_ack=1 → IDLE; done drops the following cycle.
- Latency:
  - With operands offered back-to-back, LOAD_A and LOAD_B take 1 cycle each.
  - RUN lasts B+1 cycles.
  - done rises B+3 cycles after the first LOAD_A cycle.
- B=0: RUN exits on its first cycle; P=0 (cleared in LOAD_A); iter_cnt=0.
- A=0: full B iterations; P=0.
- Product arithmetic wraps modulo 2^16 in the datapath; the controller does not flag overflow.
- start while busy: ignored.
- start and abort together in IDLE: stay in IDLE.
- res_ack outside DONE: ignored.
- in_valid outside LOAD_A/LOAD_B: ignored, in_ready=0.
- Exactly one of LdA, LdB, (LdP with decB) may be active in any cycle.
- clrP never coincides with LdP.

Test Plan:
- Reset mid-RUN:
  - Stimulus: A=7, B=9; assert rst at the 4th RUN cycle.
  - Required: next cycle state=IDLE; all outputs 0; iter_cnt=0; new start then runs normally.
- Nominal:
  - Stimulus: start; A=5, B=3 offered back-to-back, in_valid held.
  - Required: LdA at cycle 1, LdB at cycle 2; LdP+decB at cycles 3,4,5; done at cycle 7 and held.
  - Result: P=15, iter_cnt=3, err=0; res_ack → IDLE next cycle.
- Handshake stalls and B=0:
  - Stimulus: in_valid low 3 cycles in LOAD_A and 2 cycles in LOAD_B; A=9, B=0.
  - Required: in_ready stays high while waiting; no LdA/LdB until in_valid.
  - Result: RUN exits in 1 cycle; P=0, iter_cnt=0.
- Iteration limit:
  - Stimulus: MAX_ITER=4; A=3, B=10.
  - Required: exactly 4 LdP pulses; done with err=1, iter_cnt=4, P=12.
  - Next start clears err to 0.
- Abort:
  - Stimulus: A=2, B=100; assert abort in the 5th RUN cycle.
  - Required: no strobes in the abort cycle; IDLE next cycle; done never asserted; start then accepted.
- Ignored inputs:
  - Stimulus: start pulses during RUN and DONE; res_ack pulses during RUN.
  - Required: no state change; operation completes with the correct P.
